// File: rtl/fifo_pixel_unpacker_pkg.sv
// Shared types and constants for the packed-pixel FIFO unpacker.
package fifo_pixel_unpacker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  function automatic int unsigned pix_width(input int unsigned dw);
    return 3 * dw;
  endfunction

endpackage

// File: rtl/fifo_pixel_unpacker_pixel_pos_counter.sv
// Raster x/y position counter; wraps against IMG_W-1/IMG_H-1, not power-of-two overflow.
module pixel_pos_counter #(
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32,
  parameter int unsigned XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  parameter int unsigned YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last_col,
  output logic          o_last_row,
  output logic          o_last_pix
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  always_comb begin
    o_x        = r_x;
    o_y        = r_y;
    o_last_col = (r_x == X_LAST);
    o_last_row = (r_y == Y_LAST);
    o_last_pix = o_last_col & o_last_row;
  end

endmodule

// File: rtl/fifo_pixel_unpacker.sv
// Pops packed RGB words from the pixel FIFO and serialises them as tagged single-channel beats.
module fifo_pixel_unpacker
  import fifo_pixel_unpacker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMG_W      = 32,
  parameter int unsigned IMG_H      = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               fifo_empty,
  input  logic [pix_width(DATA_WIDTH)-1:0]   fifo_data,
  output logic                               fifo_rd_req,
  output logic [DATA_WIDTH-1:0]              ch_data,
  output logic [1:0]                         ch_idx,
  output logic                               ch_valid,
  input  logic                               ch_ready,
  output logic                               sof,
  output logic                               eol,
  output logic                               eof,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned PIX_WIDTH = pix_width(DATA_WIDTH);
  localparam int unsigned XW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW        = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_t                 r_state;
  state_t                 w_next;
  logic [PIX_WIDTH-1:0]   r_pix;
  logic [1:0]             r_ch_idx;
  logic [XW-1:0]          w_x;
  logic [YW-1:0]          w_y;
  logic                   w_last_col;
  logic                   w_last_row;
  logic                   w_last_pix;
  logic                   w_clear;
  logic                   w_advance;
  logic                   w_send;
  logic [DATA_WIDTH-1:0]  w_slice;

  pixel_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .XW    (XW),
    .YW    (YW)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_advance  (w_advance),
    .o_x        (w_x),
    .o_y        (w_y),
    .o_last_col (w_last_col),
    .o_last_row (w_last_row),
    .o_last_pix (w_last_pix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pix    <= '0;
      r_ch_idx <= CH_R;
    end else begin
      r_state <= w_next;
      if (fifo_rd_req) begin
        r_pix    <= fifo_data;
        r_ch_idx <= CH_R;
      end else if (w_send && ch_ready && (r_ch_idx != CH_B)) begin
        r_ch_idx <= r_ch_idx + 2'd1;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    fifo_rd_req = 1'b0;
    w_clear     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next  = ST_FETCH;
          w_clear = 1'b1;
        end
      end
      ST_FETCH: begin
        if (!fifo_empty) begin
          fifo_rd_req = 1'b1;
          w_next      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ch_ready && (r_ch_idx == CH_B)) begin
          w_advance = 1'b1;
          w_next    = w_last_pix ? ST_FIN : ST_FETCH;
        end
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_slice = '0;
    case (r_ch_idx)
      CH_R:    w_slice = r_pix[0 +: DATA_WIDTH];
      CH_G:    w_slice = r_pix[DATA_WIDTH +: DATA_WIDTH];
      default: w_slice = r_pix[2*DATA_WIDTH +: DATA_WIDTH];
    endcase
  end

  // Tags and data are gated by SEND so nothing leaks onto the stream between beats.
  always_comb begin
    w_send   = (r_state == ST_SEND);
    ch_valid = w_send;
    ch_data  = w_send ? w_slice : '0;
    ch_idx   = r_ch_idx;
    sof      = w_send & (w_x == '0) & (w_y == '0) & (r_ch_idx == CH_R);
    eol      = w_send & w_last_col & (r_ch_idx == CH_B);
    eof      = w_send & w_last_col & (r_ch_idx == CH_B) & w_last_row;
    busy     = (r_state != ST_IDLE);
    done     = (r_state == ST_FIN);
  end

endmodule

// File: doc/fifo_pixel_unpacker.md
Name: fifo_pixel_unpacker

Overview:
- Downstream consumer of the packed-pixel FIFO in the food-classification datapath.
- Pops one packed RGB word (3 x DATA_WIDTH) per pixel, in raster order.
- Serialises each word into three single-channel beats on a valid/ready stream feeding the convolution MAC front end.
- Tracks pixel column/row and tags beats with start-of-frame, end-of-line and end-of-frame markers. Signals done after IMG_W x IMG_H pixels.

Parameters:
- DATA_WIDTH, 32, width of one colour channel; FIFO word is 3*DATA_WIDTH.
- IMG_W, 32, pixels per image row (>=2).
- IMG_H, 32, rows per frame (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse to begin a frame; honoured only in IDLE.
- fifo_empty  in  1  empty flag from the upstream FIFO.
- fifo_data  in  3*DATA_WIDTH  FIFO read data; valid during a cycle in which fifo_rd_req=1.
- fifo_rd_req  out  1  FIFO pop request.
- ch_data  out  DATA_WIDTH  current channel value.
- ch_idx  out  2  channel index of the beat: 0=R, 1=G, 2=B.
- ch_valid  out  1  beat valid.
- ch_ready  in  1  downstream accept.
- sof  out  1  beat is channel 0 of pixel (0,0).
- eol  out  1  beat is channel 2 of the last pixel in a row.
- eof  out  1  beat is channel 2 of the last pixel of the frame.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE; x, y, ch_idx and the pixel register clear to 0.
  - All outputs are 0: fifo_rd_req, ch_valid, sof, eol, eof, busy, done; ch_data=0; ch_idx=0.
  - A pop in flight is abandoned. No recovery of a partially sent pixel.
- FSM states: IDLE, FETCH, SEND, FIN.
  - IDLE: start=1 -> FETCH; x=0, y=0.
  - FETCH: fifo_rd_req = (state==FETCH) & ~fifo_empty, combinational.
    - While fifo_empty=1: stay in FETCH, rd_req=0.
    - On a cycle with rd_req=1: capture fifo_data into pix_reg at the clock edge, set ch_idx=0, go to SEND.
  - SEND: ch_valid=1.
    - ch_data = pix_reg[ch_idx*DATA_WIDTH +: DATA_WIDTH], so ch0 = bits [DW-1:0] and ch2 = the top slice.
    - On ch_valid & ch_ready with ch_idx<2: ch_idx increments.
    - On ch_valid & ch_ready with ch_idx==2:
      - Pixel is finished. If x==IMG_W-1 then x=0 and y=y+1, else x=x+1.
      - Next state: FIN if the finished pixel was (IMG_W-1, IMG_H-1), otherwise FETCH.
  - FIN: done=1 for exactly one cycle -> IDLE.
- Back-pressure: while ch_valid=1 and ch_ready=0, ch_data, ch_idx, sof, eol and eof hold stable.
- Beat tags (combinational from state, x, y and ch_idx; 0 outside SEND):
  - sof = (x==0) & (y==0) & (ch_idx==0).
  - eol = (x==IMG_W-1) & (ch_idx==2).
  - eof = eol & (y==IMG_H-1).
- Latency and throughput:
  - The rd_req cycle is followed by ch_valid on the next cycle.
  - Best case is 4 cycles per pixel (1 FETCH + 3 SEND), with no prefetch.
- Counter widths: x is $clog2(IMG_W) bits, y is $clog2(IMG_H) bits.
  - Wrap comparisons are against IMG_W-1 and IMG_H-1, never against power-of-two overflow.
- Edge cases:
  - start while busy is ignored.
  - start and fifo_empty=1 in the same cycle: enter FETCH and wait there.
  - fifo_rd_req is never asserted in IDLE, SEND or FIN. An empty FIFO is never popped.

Decomposition:
- Shared package: the FSM state encoding (IDLE/FETCH/SEND/FIN, 2 bits), CH_R/CH_G/CH_B index constants, and the PIX_WIDTH = 3*DATA_WIDTH helper.
- One natural sub-module: pixel_pos_counter, the x/y raster counter with advance input, last_col/last_row/last_pix outputs and clear.
- The FSM and serialiser stay in the top module.

Test Plan:
- Reset/idle:
  - Stimulus: rst pulse, then idle 5 cycles with fifo_empty=0.
  - Required: fifo_rd_req=0, ch_valid=0, busy=0, done=0 throughout.
- Single pixel serialisation:
  - Config: DW=8, IMG_W=2, IMG_H=2. Stimulus: start, FIFO word 0x332211, ch_ready=1.
  - Required: beats 0x11/idx0/sof=1, then 0x22/idx1, then 0x33/idx2. First beat appears 1 cycle after rd_req.
- Full frame:
  - Stimulus: 4 words 0x030201, 0x060504, 0x090807, 0x0C0B0A with ch_ready=1.
  - Required: 12 beats in order. eol on beats 6 and 12, eof only on beat 12. done pulses once in the cycle after beat 12. busy drops the cycle after that.
- Empty stall:
  - Stimulus: fifo_empty=1 for 6 cycles after start, then a word arrives.
  - Required: rd_req=0 and ch_valid=0 during the stall. Exactly one pop follows.
- Back-pressure:
  - Stimulus: ch_ready=0 for 3 cycles on ch_idx=1 of word 0x332211.
  - Required: ch_data=0x22 held stable and no new pop. Resumes with 0x33.
- Mid-frame reset:
  - Stimulus: assert rst during SEND of pixel 2.
  - Required: outputs 0 immediately (asynchronously). Next start restarts at (0,0) with sof=1 on the first beat.
